ps_linebuf_ctrl: RTL and testbench

- Sequences four ps_linebuffer instances into a 3-row sliding window for 3x3 kernels in the processing core.
- Accepts a raster pixel stream and writes one line into one buffer at a time, rotating through the buffers.
- Reads the three rows the kernel needs and emits a 9-tap window with vertical edge clamping. Horizontal clamping is done inside the line buffers.
- Sits between pixel ingress and the kernel datapath.

---
 rtl/ps_pkg.sv | 38 +++
 rtl/ps_linebuffer.sv | 68 ++++++
 rtl/ps_row_sel.sv | 37 +++
 rtl/ps_linebuf_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ps_linebuf_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps_pkg
// Brief    : Shared types and helpers for the line-buffer window controller.
// Revision : 1.0 - initial release
// ============================================================================
package ps_pkg;

    localparam int NUM_LB = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

    // Buffer selects for the three window rows, packed top first.
    typedef struct packed {
        logic [SEL_W-1:0] top;
        logic [SEL_W-1:0] mid;
        logic [SEL_W-1:0] bot;
    } tap_sel_t;

    function automatic tap_sel_t pack_taps(
        input logic [SEL_W-1:0] top,
        input logic [SEL_W-1:0] mid,
        input logic [SEL_W-1:0] bot
    );
        tap_sel_t t;
        t.top = top;
        t.mid = mid;
        t.bot = bot;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps_linebuffer.sv
`default_nettype none
// ============================================================================
// Module   : ps_linebuffer
// Brief    : One-line pixel store; each read emits {left, centre, right} taps.
// Revision : 1.0 - initial release
// ============================================================================
module ps_linebuffer #(
    parameter int LINE_LENGTH = 640,
    parameter int DATA_WIDTH  = 3,
    parameter int CLAMP_EDGES = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_wr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic                    i_rd,
    output logic [3*DATA_WIDTH-1:0] o_taps
);

    localparam int PTR_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam logic [PTR_W-1:0] c_last = PTR_W'(LINE_LENGTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [LINE_LENGTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      w_left_idx;
    logic [PTR_W-1:0]      w_right_idx;
    logic [DATA_WIDTH-1:0] w_left;
    logic [DATA_WIDTH-1:0] w_right;

    // Edge neighbours either replicate the edge pixel or read as zero.
    always_comb begin
        w_left_idx  = (r_rd_ptr == '0)     ? '0     : r_rd_ptr - PTR_W'(1);
        w_right_idx = (r_rd_ptr == c_last) ? c_last : r_rd_ptr + PTR_W'(1);
        w_left      = r_mem[w_left_idx];
        w_right     = r_mem[w_right_idx];
        if (CLAMP_EDGES == 0 && r_rd_ptr == '0) begin
            w_left = '0;
        end
        if (CLAMP_EDGES == 0 && r_rd_ptr == c_last) begin
            w_right = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            o_taps   <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + PTR_W'(1);
                o_taps   <= {w_left, r_mem[r_rd_ptr], w_right};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps_row_sel.sv
`default_nettype none
// ============================================================================
// Module   : ps_row_sel
// Brief    : Maps an output row to top/mid/bot buffer selects with edge clamping.
// Revision : 1.0 - initial release
// ============================================================================
module ps_row_sel
    import ps_pkg::*;
#(
    parameter int FRAME_HEIGHT = 480,
    parameter int LINE_W       = 10
) (
    input  logic [LINE_W-1:0] i_rd_row,
    output tap_sel_t          o_sel,
    output logic [NUM_LB-1:0] o_rd_mask
);

    localparam logic [LINE_W-1:0] c_last_row = LINE_W'(FRAME_HEIGHT - 1);

    logic [SEL_W-1:0] w_top;
    logic [SEL_W-1:0] w_mid;
    logic [SEL_W-1:0] w_bot;

    // Buffer index is the line number mod NUM_LB, so only the low bits matter.
    always_comb begin
        w_mid     = i_rd_row[SEL_W-1:0];
        w_top     = (i_rd_row == '0) ? w_mid : w_mid - SEL_W'(1);
        w_bot     = (i_rd_row >= c_last_row) ? w_mid : w_mid + SEL_W'(1);
        o_sel     = pack_taps(w_top, w_mid, w_bot);
        o_rd_mask = '0;
        o_rd_mask[w_top] = 1'b1;
        o_rd_mask[w_mid] = 1'b1;
        o_rd_mask[w_bot] = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/ps_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps_linebuf_ctrl
// Brief    : Rotates four line buffers into a 3-row sliding window for 3x3 kernels.
// Revision : 1.0 - initial release
// ============================================================================
module ps_linebuf_ctrl
    import ps_pkg::*;
#(
    parameter int LINE_LENGTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int DATA_WIDTH   = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_valid,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic                            o_ready,
    input  logic                            i_ready,
    output logic                            o_valid,
    output logic [9*DATA_WIDTH-1:0]         o_window,
    output logic                            o_sol,
    output logic [$clog2(FRAME_HEIGHT)-1:0] o_row,
    output logic                            o_frame_done
);

    localparam int COL_W  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int ROW_W  = $clog2(FRAME_HEIGHT);
    localparam int LINE_W = $clog2(FRAME_HEIGHT + 2) + 1;
    localparam logic [COL_W-1:0]  c_last_col    = COL_W'(LINE_LENGTH - 1);
    localparam logic [LINE_W-1:0] c_frame_lines = LINE_W'(FRAME_HEIGHT);
    localparam logic [LINE_W-1:0] c_last_row    = LINE_W'(FRAME_HEIGHT - 1);

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [COL_W-1:0]   r_wr_col;
    logic [SEL_W-1:0]   r_wr_sel;
    logic [LINE_W-1:0]  r_wr_line;
    logic [LINE_W-1:0]  r_rd_row;
    logic [COL_W-1:0]   r_rd_col;
    logic [LINE_W-1:0]  w_rows_ahead;
    logic [LINE_W-1:0]  w_need;
    logic               w_wr_en;
    logic               w_issue;
    tap_sel_t           w_sel;
    tap_sel_t           r_sel_q;
    logic [NUM_LB-1:0]  w_rd_mask;
    logic [3*DATA_WIDTH-1:0] w_lb_taps [NUM_LB];

    // Line w reuses the buffer of line w-4, last needed by row w-3.
    assign o_ready = (r_wr_line <= r_rd_row + LINE_W'(2)) && (r_wr_line < c_frame_lines);
    assign w_wr_en = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rstn || r_state == ST_DONE) begin
            r_wr_col  <= '0;
            r_wr_sel  <= '0;
            r_wr_line <= '0;
        end else if (w_wr_en) begin
            if (r_wr_col == c_last_col) begin
                r_wr_col  <= '0;
                r_wr_sel  <= r_wr_sel + SEL_W'(1);
                r_wr_line <= r_wr_line + LINE_W'(1);
            end else begin
                r_wr_col  <= r_wr_col + COL_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_rows_ahead = r_rd_row + LINE_W'(2);
        w_need       = (w_rows_ahead > c_frame_lines) ? c_frame_lines : w_rows_ahead;
        case (r_state)
            ST_IDLE: begin
                if (r_wr_line >= w_need) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (i_ready) begin
                    w_issue = 1'b1;
                    if (r_rd_col == c_last_col) begin
                        w_state_nxt = (r_rd_row >= c_last_row) ? ST_DONE : ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= ST_IDLE;
            r_rd_row <= '0;
            r_rd_col <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DONE) begin
                r_rd_row <= '0;
                r_rd_col <= '0;
            end else if (w_issue) begin
                if (r_rd_col == c_last_col) begin
                    r_rd_col <= '0;
                    r_rd_row <= r_rd_row + LINE_W'(1);
                end else begin
                    r_rd_col <= r_rd_col + COL_W'(1);
                end
            end
        end
    end

    ps_row_sel #(
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .LINE_W       (LINE_W)
    ) u_row_sel (
        .i_rd_row  (r_rd_row),
        .o_sel     (w_sel),
        .o_rd_mask (w_rd_mask)
    );

    // A buffer shared by two taps is read once so its pointers stay line-aligned.
    for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
        ps_linebuffer #(
            .LINE_LENGTH (LINE_LENGTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .CLAMP_EDGES (1)
        ) u_lb (
            .i_clk     (i_clk),
            .i_rstn    (i_rstn),
            .i_wr      (w_wr_en && (r_wr_sel == SEL_W'(g))),
            .i_wr_data (i_data),
            .i_rd      (w_issue && w_rd_mask[g]),
            .o_taps    (w_lb_taps[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_sol   <= 1'b0;
            o_row   <= '0;
            r_sel_q <= '0;
        end else begin
            o_valid <= w_issue;
            o_sol   <= w_issue && (r_rd_col == '0);
            if (w_issue) begin
                o_row   <= r_rd_row[ROW_W-1:0];
                r_sel_q <= w_sel;
            end
        end
    end

    assign o_window     = {w_lb_taps[r_sel_q.top], w_lb_taps[r_sel_q.mid], w_lb_taps[r_sel_q.bot]};
    assign o_frame_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ps_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_linebuf_ctrl
// Brief    : Self-checking bench for ps_linebuf_ctrl (4x4 and 4x2 frames, 8-bit pixels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_linebuf_ctrl;

    localparam int LL = 4;

    typedef struct {
        logic [71:0] win;
        logic        sol;
        int          row;
        int          col;
    } sb_t;

    typedef struct {
        int          fh;
        int          row;
        int          col;
        logic [71:0] win;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        v4, rdy4, or4, ov4, sol4, fd4;
    logic [7:0]  d4;
    logic [71:0] win4;
    logic [1:0]  row4;
    logic        v2, rdy2, or2, ov2, sol2, fd2;
    logic [7:0]  d2;
    logic [71:0] win2;
    logic [0:0]  row2;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt4 = 0, dcnt4 = 0, vcnt2 = 0, dcnt2 = 0;
    int acc4 = 0, acc_tot4 = 0, viol4 = 0;
    bit gate4 = 1'b0;
    bit abort = 1'b0;
    bit busy  = 1'b0;
    sb_t sb4[$];
    sb_t sb2[$];
    sb_t it4, it2;
    logic [71:0] cap4 [16];
    logic [71:0] cap2 [8];
    vec_t tbl [5];

    always #5 clk = ~clk;

    ps_linebuf_ctrl #(.LINE_LENGTH(4), .FRAME_HEIGHT(4), .DATA_WIDTH(8)) u_dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(v4), .i_data(d4), .o_ready(or4),
        .i_ready(rdy4), .o_valid(ov4), .o_window(win4), .o_sol(sol4), .o_row(row4),
        .o_frame_done(fd4)
    );

    ps_linebuf_ctrl #(.LINE_LENGTH(4), .FRAME_HEIGHT(2), .DATA_WIDTH(8)) u_dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(v2), .i_data(d2), .o_ready(or2),
        .i_ready(rdy2), .o_valid(ov2), .o_window(win2), .o_sol(sol2), .o_row(row2),
        .o_frame_done(fd2)
    );

    function automatic logic [7:0] pix(input int l, input int c);
        return 8'(16 * l + c);
    endfunction

    function automatic logic [71:0] model_win(input int r, input int c, input int fh);
        logic [71:0] w;
        int lines [3];
        int cl, cr;
        w  = '0;
        lines[0] = (r > 0) ? r - 1 : 0;
        lines[1] = r;
        lines[2] = (r < fh - 1) ? r + 1 : fh - 1;
        cl = (c > 0) ? c - 1 : 0;
        cr = (c < LL - 1) ? c + 1 : LL - 1;
        for (int k = 0; k < 3; k++) begin
            w = {w[47:0], pix(lines[k], cl), pix(lines[k], c), pix(lines[k], cr)};
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push_exp(input int which, input int nf, input int fh);
        sb_t it;
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < fh; r++)
                for (int c = 0; c < LL; c++) begin
                    it.win = model_win(r, c, fh);
                    it.sol = (c == 0);
                    it.row = r;
                    it.col = c;
                    if (which == 0) sb4.push_back(it);
                    else            sb2.push_back(it);
                end
    endtask

    task automatic send(input int which, input int nf, input int fh);
        bit ok;
        int tries;
        busy = 1'b1;
        for (int f = 0; f < nf; f++)
            for (int l = 0; l < fh; l++)
                for (int c = 0; c < LL; c++) begin
                    ok = 1'b0;
                    tries = 0;
                    while (!ok && !abort) begin
                        @(negedge clk);
                        if (which == 0) begin v4 = 1'b1; d4 = pix(l, c); ok = or4; end
                        else            begin v2 = 1'b1; d2 = pix(l, c); ok = or2; end
                        tries++;
                        if (!ok && tries >= 200) begin
                            fail_now("send_timeout");
                            abort = 1'b1;
                        end
                    end
                end
        @(negedge clk);
        v4 = 1'b0;
        v2 = 1'b0;
        busy = 1'b0;
    endtask

    task automatic wait_done(input int which, input int target);
        int n;
        n = 0;
        while (((which == 0) ? dcnt4 : dcnt2) < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (((which == 0) ? dcnt4 : dcnt2) < target) fail_now("frame_done_wait");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now("source_idle_wait");
    endtask

    task automatic check_table(input int fh);
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].fh == fh) begin
                chk($sformatf("tbl%0d_window", i),
                    (fh == 4) ? cap4[tbl[i].row * LL + tbl[i].col] : cap2[tbl[i].row * LL + tbl[i].col],
                    tbl[i].win);
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            acc4  = 0;
            gate4 = 1'b0;
        end else if (v4 && or4) begin
            acc4++;
            acc_tot4++;
            if (acc4 == 16) begin
                gate4 = 1'b1;
                acc4  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (ov4) begin
                vcnt4++;
                if (sb4.size() == 0) fail_now("sb4_unexpected_window");
                else begin
                    it4 = sb4.pop_front();
                    chk("win4", win4, it4.win);
                    chk("sol4", 72'(sol4), 72'(it4.sol));
                    chk("row4", 72'(row4), 72'(it4.row));
                    cap4[it4.row * LL + it4.col] = win4;
                end
            end
            if (fd4) begin
                dcnt4++;
                gate4 = 1'b0;
            end else if (gate4 && or4) begin
                viol4++;
            end
            if (ov2) begin
                vcnt2++;
                if (sb2.size() == 0) fail_now("sb2_unexpected_window");
                else begin
                    it2 = sb2.pop_front();
                    chk("win2", win2, it2.win);
                    chk("sol2", 72'(sol2), 72'(it2.sol));
                    chk("row2", 72'(row2), 72'(it2.row));
                    cap2[it2.row * LL + it2.col] = win2;
                end
            end
            if (fd2) dcnt2++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv, bd, ba, n;
        tbl[0] = '{4, 0, 0, 72'h00_00_01_00_00_01_10_10_11};
        tbl[1] = '{4, 3, 3, 72'h22_23_23_32_33_33_32_33_33};
        tbl[2] = '{4, 1, 2, 72'h01_02_03_11_12_13_21_22_23};
        tbl[3] = '{2, 0, 1, 72'h00_01_02_00_01_02_10_11_12};
        tbl[4] = '{2, 1, 0, 72'h00_00_01_10_10_11_10_10_11};

        rstn = 1'b0; v4 = 1'b0; v2 = 1'b0; d4 = '0; d2 = '0; rdy4 = 1'b1; rdy2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 72'(ov4), 72'(0));
        chk("rst_ready", 72'(or4), 72'(1));
        chk("rst_window", win4, 72'(0));
        chk("rst_sol", 72'(sol4), 72'(0));
        chk("rst_row", 72'(row4), 72'(0));
        chk("rst_frame_done", 72'(fd4), 72'(0));
        rstn = 1'b1;

        // Continuous frame
        push_exp(0, 1, 4);
        bv = vcnt4; bd = dcnt4;
        send(0, 1, 4);
        wait_done(0, bd + 1);
        chk("s1_windows", 72'(vcnt4 - bv), 72'(16));
        chk("s1_sb_left", 72'(sb4.size()), 72'(0));
        check_table(4);

        // Three-cycle downstream stall in row 1
        push_exp(0, 1, 4);
        bv = vcnt4; bd = dcnt4;
        fork send(0, 1, 4); join_none
        n = 0;
        while (!(ov4 && row4 == 2'd1 && sol4) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) fail_now("s2_row1_wait");
        rdy4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("s2_stall%0d_valid", k), 72'(ov4), 72'(0));
        end
        rdy4 = 1'b1;
        wait_done(0, bd + 1);
        wait_idle();
        chk("s2_windows", 72'(vcnt4 - bv), 72'(16));
        chk("s2_done_pulses", 72'(dcnt4 - bd), 72'(1));
        chk("s2_sb_left", 72'(sb4.size()), 72'(0));

        // Reader held off: writer stops after three lines
        push_exp(0, 1, 4);
        bv = vcnt4; bd = dcnt4; ba = acc_tot4;
        rdy4 = 1'b0;
        fork send(0, 1, 4); join_none
        repeat (40) @(negedge clk);
        chk("s3_accepted_stalled", 72'(acc_tot4 - ba), 72'(12));
        chk("s3_ready_low", 72'(or4), 72'(0));
        chk("s3_no_windows", 72'(vcnt4 - bv), 72'(0));
        rdy4 = 1'b1;
        wait_done(0, bd + 1);
        wait_idle();
        chk("s3_accepted_total", 72'(acc_tot4 - ba), 72'(16));
        chk("s3_windows", 72'(vcnt4 - bv), 72'(16));

        // Back-to-back frames
        push_exp(0, 2, 4);
        bv = vcnt4; bd = dcnt4;
        send(0, 2, 4);
        wait_done(0, bd + 2);
        chk("s4_windows", 72'(vcnt4 - bv), 72'(32));
        chk("s4_ready_while_full", 72'(viol4), 72'(0));
        chk("s4_sb_left", 72'(sb4.size()), 72'(0));

        // Reset in the middle of row 1
        push_exp(0, 1, 4);
        fork send(0, 1, 4); join_none
        n = 0;
        while (!(ov4 && row4 == 2'd1 && !sol4) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) fail_now("s5_row1_wait");
        rstn  = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        chk("s5_valid_after_reset", 72'(ov4), 72'(0));
        chk("s5_ready_after_reset", 72'(or4), 72'(1));
        wait_idle();
        sb4.delete();
        rstn  = 1'b1;
        abort = 1'b0;
        push_exp(0, 1, 4);
        bv = vcnt4; bd = dcnt4;
        send(0, 1, 4);
        wait_done(0, bd + 1);
        chk("s5_windows", 72'(vcnt4 - bv), 72'(16));
        chk("s5_sb_left", 72'(sb4.size()), 72'(0));
        check_table(4);

        // Two-line frame
        push_exp(1, 1, 2);
        bv = vcnt2; bd = dcnt2;
        send(1, 1, 2);
        wait_done(1, bd + 1);
        chk("s6_windows", 72'(vcnt2 - bv), 72'(8));
        chk("s6_done_pulses", 72'(dcnt2 - bd), 72'(1));
        chk("s6_sb_left", 72'(sb2.size()), 72'(0));
        check_table(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
